// File: rtl/uart_fifo_bridge.sv
// Byte-buffering bridge between the memory stage and the UART ser/des pair:
// RX FIFO feeding core loads, TX FIFO drained into the serializer by a small FSM.
module uart_fifo_bridge #(
  parameter int DEPTH = 16,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       uart_rd_en,
  output logic [7:0] uart_rx_data,
  output logic       empty,
  input  logic       uart_wr_en,
  input  logic [7:0] uart_tx_data,
  output logic       full,
  input  logic       rx_valid,
  input  logic [7:0] rx_data,
  output logic       tx_start,
  output logic [7:0] tx_data,
  input  logic       tx_busy,
  output logic       rx_overrun
);
  localparam int          CW       = AW + 1;
  localparam logic [AW:0] CNT_FULL = CW'(DEPTH);

  typedef enum logic [1:0] {IDLE, START, WAIT_BUSY, WAIT_DONE} state_t;
  state_t state, state_nx;

  // RX FIFO
  logic [7:0]    rx_mem [DEPTH];
  logic [AW-1:0] rx_wptr, rx_rptr;
  logic [AW:0]   rx_count;
  logic          rx_push, rx_pop;

  assign empty        = (rx_count == '0);
  assign rx_push      = rx_valid && (rx_count != CNT_FULL);
  assign rx_pop       = uart_rd_en && !empty;
  assign uart_rx_data = empty ? 8'h00 : rx_mem[rx_rptr];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_wptr    <= '0;
      rx_rptr    <= '0;
      rx_count   <= '0;
      rx_overrun <= 1'b0;
    end else begin
      if (rx_push) rx_wptr <= rx_wptr + AW'(1);
      if (rx_pop)  rx_rptr <= rx_rptr + AW'(1);
      rx_count <= rx_count + CW'(rx_push) - CW'(rx_pop);
      if (rx_valid && !rx_push) rx_overrun <= 1'b1;
    end
  end

  // Storage needs no reset: reads are masked while the FIFO is empty.
  always_ff @(posedge clk) begin
    if (rx_push) rx_mem[rx_wptr] <= rx_data;
  end

  // TX FIFO
  logic [7:0]    tx_mem [DEPTH];
  logic [AW-1:0] tx_wptr, tx_rptr;
  logic [AW:0]   tx_count;
  logic          tx_push, tx_pop;

  assign full    = (tx_count == CNT_FULL);
  assign tx_push = uart_wr_en && !full;
  assign tx_pop  = (state == IDLE) && (tx_count != '0) && !tx_busy;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tx_wptr  <= '0;
      tx_rptr  <= '0;
      tx_count <= '0;
      tx_data  <= 8'h00;
    end else begin
      if (tx_push) tx_wptr <= tx_wptr + AW'(1);
      if (tx_pop) begin
        tx_rptr <= tx_rptr + AW'(1);
        tx_data <= tx_mem[tx_rptr];
      end
      tx_count <= tx_count + CW'(tx_push) - CW'(tx_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (tx_push) tx_mem[tx_wptr] <= uart_tx_data;
  end

  // Drain FSM: one byte in flight, handshake on tx_busy rise then fall.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:      if (tx_pop)   state_nx = START;
      START:                   state_nx = WAIT_BUSY;
      WAIT_BUSY: if (tx_busy)  state_nx = WAIT_DONE;
      WAIT_DONE: if (!tx_busy) state_nx = IDLE;
      default:                 state_nx = IDLE;
    endcase
  end

  // Decoded from the async-reset state register, so it drops as soon as rst rises.
  assign tx_start = (state == START);

endmodule
